// File: rtl/xbus_master.sv
// Xbus initiator: runs one host command as a single xbus read or write and returns data plus
// an OK / NXM / TIMEOUT status, so a bad address can never hang the host.
module xbus_master #(
    parameter int NXM_CYCLES = 8,
    parameter int ACK_CYCLES = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [21:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err,
    output logic        req,
    output logic        write,
    output logic [21:0] addr,
    output logic [31:0] dataout,
    input  logic [31:0] datain,
    input  logic        decode,
    input  logic        ack,
    output logic        busy
);

    localparam logic [1:0]       ERR_OK      = 2'b00;
    localparam logic [1:0]       ERR_NXM     = 2'b01;
    localparam logic [1:0]       ERR_TIMEOUT = 2'b10;
    localparam logic [CNT_W-1:0] NXM_LAST    = CNT_W'(NXM_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, REQ, RECOVER, RESP} state_t;

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic             write_q, write_d;
    logic [21:0]      addr_q, addr_d;
    logic [31:0]      dataout_q, dataout_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seen_q, seen_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             bus_done;
    logic [1:0]       done_err;
    logic [31:0]      done_data;

    // One counter serves NXM wait, decode-to-ack wait and the recovery gap; it sticks at all-ones.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        // NOTE: every _d starts from its held value so no branch leaves it unassigned (no latch).
        state_d     = state_q;
        req_d       = req_q;
        write_d     = write_q;
        addr_d      = addr_q;
        dataout_d   = dataout_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        bus_done    = 1'b0;
        done_err    = ERR_OK;
        done_data   = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    write_d   = cmd_write;
                    addr_d    = cmd_addr;
                    dataout_d = cmd_data;
                    req_d     = 1'b1;
                    cnt_d     = '0;
                    seen_d    = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                if (decode && !seen_q) begin
                    seen_d = 1'b1;
                    cnt_d  = '0;
                end
                // ack wins over both timeouts; a decode arriving this cycle is not an NXM.
                if (ack) begin
                    bus_done  = 1'b1;
                    done_data = write_q ? '0 : datain;
                end else if (!seen_q && !decode && cnt_q == NXM_LAST) begin
                    bus_done = 1'b1;
                    done_err = ERR_NXM;
                end else if (seen_q && cnt_q == ACK_LAST) begin
                    bus_done = 1'b1;
                    done_err = ERR_TIMEOUT;
                end
                if (bus_done) begin
                    req_d      = 1'b0;
                    rsp_data_d = done_data;
                    rsp_err_d  = done_err;
                    cnt_d      = '0;
                    state_d    = RECOVER;
                end
            end
            RECOVER: begin
                // Two idle bus cycles let the slave ack pipeline drain before the next request.
                if (cnt_q == CNT_ONE) begin
                    rsp_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking only, so every flop samples the pre-edge _d values together.
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            dataout_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_OK;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            dataout_q   <= dataout_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign req       = req_q;
    assign write     = write_q;
    assign addr      = addr_q;
    assign dataout   = dataout_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_xbus_master.sv
// Randomized scoreboard bench for xbus_master: a model slave on the bus, a reference model
// that predicts data/status/latency per command, and a monitor that checks each response.
`timescale 1ns/1ps
module tb_xbus_master;

    localparam int P          = 10;
    localparam int NXM_CYCLES = 8;
    localparam int ACK_CYCLES = 64;
    localparam int BOUND      = 300;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [21:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        req;
    logic        write;
    logic [21:0] addr;
    logic [31:0] dataout;
    logic [31:0] datain;
    logic        decode;
    logic        ack;
    logic        busy;

    xbus_master #(
        .NXM_CYCLES(NXM_CYCLES),
        .ACK_CYCLES(ACK_CYCLES),
        .CNT_W     (7)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .req      (req),
        .write    (write),
        .addr     (addr),
        .dataout  (dataout),
        .datain   (datain),
        .decode   (decode),
        .ack      (ack),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #(P/2) clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, BOUND);
    endtask

    // Address map: 0x3FF6xx acking slave, 0x3FF7xx decodes but never acks, rest unmapped.
    function automatic bit in_ack_region(input logic [21:0] a);
        return a[21:8] == 14'h3FF6;
    endfunction

    function automatic bit in_silent_region(input logic [21:0] a);
        return a[21:8] == 14'h3FF7;
    endfunction

    function automatic logic [31:0] init_val(input int i);
        return (i == 0) ? 32'o12345 : 32'hA5A50000 + 32'(i);
    endfunction

    // Model slave: combinational decode, ack two clocks after decode, write lands on ack.
    logic [31:0] slave_mem [256];
    logic        ack_d1, ack_d2;
    logic        mem_init;

    assign decode = req && (in_ack_region(addr) || in_silent_region(addr));
    assign ack    = ack_d2;
    assign datain = slave_mem[addr[7:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) slave_mem[i] <= init_val(i);
            ack_d1 <= 1'b0;
            ack_d2 <= 1'b0;
        end else begin
            if (req && write && ack && in_ack_region(addr)) slave_mem[addr[7:0]] <= dataout;
            ack_d1 <= req && in_ack_region(addr);
            ack_d2 <= ack_d1;
        end
    end

    // Reference model: outcome from the address map; lat = cycle (1 = first after accept) of first rsp_valid.
    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
        int          lat;
        longint      t0;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [256];
    longint      last_hs_t = 0;

    function automatic exp_t model(input logic w, input logic [21:0] a, input logic [31:0] d);
        exp_t e;
        e.t0 = 0;
        if (in_ack_region(a)) begin
            e.err = 2'b00;
            e.lat = 3 + 3;                    // req 3 cycles, 2 recover, then response
            if (w) begin
                model_mem[a[7:0]] = d;
                e.data = '0;
            end else begin
                e.data = model_mem[a[7:0]];
            end
        end else if (in_silent_region(a)) begin
            e.err  = 2'b10;
            e.data = '0;
            e.lat  = (1 + ACK_CYCLES) + 3;    // decode cycle plus ACK_CYCLES waiting
        end else begin
            e.err  = 2'b01;
            e.data = '0;
            e.lat  = NXM_CYCLES + 3;
        end
        return e;
    endfunction

    // Host response acceptance: 0 random, 1 held low, 2 always ready.
    int ready_mode = 2;
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       rsp_ready = ($urandom_range(0, 2) != 0);
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: sampled 2ns after the falling edge, well away from the rising edge.
    initial begin
        bit          in_rsp;
        longint      first_t;
        logic [31:0] snap_d;
        logic [1:0]  snap_e;
        exp_t        e;
        int          k;
        in_rsp = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                in_rsp = 1'b0;
            end else if (rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp  = 1'b1;
                    first_t = $time;
                    snap_d  = rsp_data;
                    snap_e  = rsp_err;
                end else begin
                    check("rsp_data_stable", rsp_data, snap_d);
                    check("rsp_err_stable", rsp_err, snap_e);
                end
                check("cmd_ready_in_resp", cmd_ready, 0);
                check("req_in_resp", req, 0);
                if (rsp_ready) begin
                    in_rsp = 1'b0;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_rsp: data 0x%0h err %0d with no command pending",
                                 rsp_data, rsp_err);
                    end else begin
                        e = exp_q.pop_front();
                        k = int'((first_t - e.t0 - (P/2 + 2)) / P) + 1;
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_err", rsp_err, e.err);
                        check("rsp_latency", k, e.lat);
                    end
                    @(posedge clk);
                    last_hs_t = $time;
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [21:0] a, input logic [31:0] d,
                         input bit expect_rsp, output longint t0);
        exp_t e;
        int   n;
        @(negedge clk);
        cmd_write = w;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        n = 0;
        #2;
        while (!cmd_ready && n < BOUND) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!cmd_ready) begin
            fail_bound("cmd_accept");
            cmd_valid = 1'b0;
            t0 = 0;
            return;
        end
        @(posedge clk);
        t0 = $time;
        if (expect_rsp) begin
            e    = model(w, a, d);
            e.t0 = t0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        #2;
        while ((busy || exp_q.size() != 0) && n < BOUND) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (busy || exp_q.size() != 0) fail_bound(name);
    endtask

    initial begin
        #(P * 60000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint t0, t0b;
        int     n;
        reset     = 1'b1;
        mem_init  = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_req", req, 0);
        check("rst_write", write, 0);
        check("rst_addr", addr, 0);
        check("rst_dataout", dataout, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        reset    = 1'b0;
        mem_init = 1'b0;

        // Nominal read, write, read-back of the written word.
        issue(1'b0, 22'o17773000, 32'h0, 1'b1, t0);
        wait_idle("t1_read");
        issue(1'b1, 22'o17773005, 32'o45, 1'b1, t0);
        wait_idle("t2_write");
        check("t2_slave_mem", slave_mem[5], 32'o45);
        issue(1'b0, 22'o17773005, 32'h0, 1'b1, t0);
        wait_idle("t2_readback");

        // Unmapped address, then a slave that decodes but never acks, then a normal read.
        issue(1'b0, 22'o00000000, 32'h0, 1'b1, t0);
        wait_idle("t3_nxm");
        issue(1'b0, 22'o17773400, 32'h0, 1'b1, t0);
        wait_idle("t4_timeout");
        issue(1'b0, 22'o17773001, 32'h0, 1'b1, t0);
        wait_idle("t4_recover");

        // Host stalls the response while the next command is already waiting.
        ready_mode = 1;
        issue(1'b0, 22'o17773002, 32'h0, 1'b1, t0);
        n = 0;
        @(negedge clk);
        #2;
        while (!rsp_valid && n < BOUND) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!rsp_valid) fail_bound("t5_rsp_valid");
        cmd_write = 1'b1;
        cmd_addr  = 22'o17773003;
        cmd_data  = 32'hDEAD_BEEF;
        cmd_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            #2;
            check("t5_rsp_valid_held", rsp_valid, 1);
            check("t5_cmd_ready", cmd_ready, 0);
            check("t5_req", req, 0);
        end
        ready_mode = 2;
        issue(1'b1, 22'o17773003, 32'hDEAD_BEEF, 1'b1, t0b);
        check("t5_accept_after_hs", t0b - last_hs_t, P);
        wait_idle("t5_second");

        // Reset during cycle 2 of a read: bus released, no response for the aborted command.
        issue(1'b0, 22'o17773004, 32'h0, 1'b0, t0);
        @(negedge clk);
        #2;
        check("t6_req_before_reset", req, 1);
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("t6_req", req, 0);
        check("t6_busy", busy, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        check("t6_still_idle", busy, 0);
        check("t6_no_rsp", rsp_valid, 0);

        // Randomized mix with a randomly stalling host.
        ready_mode = 0;
        for (int i = 0; i < 40; i++) begin
            int          r;
            logic        w;
            logic [21:0] a;
            logic [31:0] d;
            r = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (r <= 6) begin
                a = {14'h3FF6, 4'h0, 4'($urandom_range(0, 15))};
            end else if (r <= 8) begin
                a = 22'($urandom);
                if (a[21:9] == 13'h1FFB) a[21] = 1'b0;
            end else begin
                a = {14'h3FF7, 8'($urandom)};
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(w, a, d, 1'b1, t0);
        end
        wait_idle("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
